// File: rtl/nubus_master_arbiter_if.sv
// Bundle between NUM_REQ local requesters, the arbiter, and the nubus CPU-side master port.
// master modport is the arbiter's view; slave modport is the requester/nubus-master view.
interface nubus_master_arbiter_if #(
   parameter int NUM_REQ = 2
);
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_wdata;
   logic [4*NUM_REQ-1:0]  req_write;
   logic [NUM_REQ-1:0]    req_lock;
   logic [NUM_REQ-1:0]    req_ready;
   logic [31:0]           req_rdata;
   logic [GW-1:0]         req_grant;

   logic                  cpu_valid;
   logic [31:0]           cpu_addr;
   logic [31:0]           cpu_wdata;
   logic [3:0]            cpu_write;
   logic                  cpu_lock;
   logic                  cpu_ready;
   logic [31:0]           cpu_rdata;

   modport master (
      input  req_valid, req_addr, req_wdata, req_write, req_lock, cpu_ready, cpu_rdata,
      output req_ready, req_rdata, req_grant,
             cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock
   );

   modport slave (
      output req_valid, req_addr, req_wdata, req_write, req_lock, cpu_ready, cpu_rdata,
      input  req_ready, req_rdata, req_grant,
             cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock
   );
endinterface

// File: rtl/nubus_master_arbiter.sv
// Shares the nubus CPU-side master port among NUM_REQ requesters with round-robin grant and lock hold.
// Build option NUBUS_ARB_FIXED_PRIO_EN: IDLE arbitration becomes fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | nothing outstanding; arbitrate among req_valid
// ISSUE | cpu_valid high with latched fields; wait for cpu_ready
// DONE  | one-cycle req_ready pulse to the granted requester
// HOLD  | bus locked; only req_grant's requester may issue
module nubus_master_arbiter #(
   parameter int NUM_REQ = 2
) (
   input logic                   nub_clkn,
   input logic                   nub_resetn,
   nubus_master_arbiter_if.master bus
);
   localparam int GW = $clog2(NUM_REQ);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]    state;
   logic [GW-1:0] grant;
   logic [GW-1:0] win;
   logic [GW-1:0] src;
   logic          any;
   int unsigned   idx;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_write;
   logic          sel_lock;

   assign bus.req_grant = grant;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      win = grant;
      any = 1'b0;
      idx = 0;
`ifdef NUBUS_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[GW'(i)]) begin
            win = GW'(i);
            any = 1'b1;
         end
      end
`else
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(grant) + k) % NUM_REQ;
         if (bus.req_valid[GW'(idx)]) begin
            win = GW'(idx);
            any = 1'b1;
         end
      end
`endif
   end

   // HOLD re-issues for the locked owner; IDLE issues for the arbitration winner.
   always_comb begin
      src       = (state == HOLD) ? grant : win;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = '0;
      sel_lock  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src == GW'(i)) begin
            sel_addr  = bus.req_addr[32*i +: 32];
            sel_wdata = bus.req_wdata[32*i +: 32];
            sel_write = bus.req_write[4*i +: 4];
            sel_lock  = bus.req_lock[i];
         end
      end
   end

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state         <= IDLE;
         grant         <= GW'(NUM_REQ - 1);
         bus.cpu_valid <= 1'b0;
         bus.cpu_addr  <= '0;
         bus.cpu_wdata <= '0;
         bus.cpu_write <= '0;
         bus.cpu_lock  <= 1'b0;
         bus.req_ready <= '0;
         bus.req_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.cpu_valid <= 1'b0;
               if (any) begin
                  bus.cpu_addr  <= sel_addr;
                  bus.cpu_wdata <= sel_wdata;
                  bus.cpu_write <= sel_write;
                  bus.cpu_lock  <= sel_lock;
                  bus.cpu_valid <= 1'b1;
                  grant         <= win;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.cpu_ready) begin
                  bus.cpu_valid        <= 1'b0;
                  bus.req_rdata        <= bus.cpu_rdata;
                  bus.req_ready[grant] <= 1'b1;
                  state                <= DONE;
               end
            end
            DONE: begin
               bus.req_ready <= '0;
               state         <= bus.cpu_lock ? HOLD : IDLE;
            end
            HOLD: begin
               if (!bus.req_lock[grant]) begin
                  bus.cpu_lock <= 1'b0;
                  state        <= IDLE;
               end else if (bus.req_valid[grant]) begin
                  bus.cpu_addr  <= sel_addr;
                  bus.cpu_wdata <= sel_wdata;
                  bus.cpu_write <= sel_write;
                  bus.cpu_valid <= 1'b1;
                  state         <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Directed bench for nubus_master_arbiter: a NUM_REQ=2 instance for issue/lock/reset/contention
// and a NUM_REQ=4 instance for pointer wrap-around.
module tb_nubus_master_arbiter;
   logic clk = 1'b0;
   logic rst2;
   logic rst4;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   nubus_master_arbiter_if #(.NUM_REQ(2)) b2 ();
   nubus_master_arbiter_if #(.NUM_REQ(4)) b4 ();

   nubus_master_arbiter #(.NUM_REQ(2)) d2 (.nub_clkn(clk), .nub_resetn(rst2), .bus(b2));
   nubus_master_arbiter #(.NUM_REQ(4)) d4 (.nub_clkn(clk), .nub_resetn(rst4), .bus(b4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run4(input logic [1:0] g);
      logic [3:0] oh;
      oh = 4'b0001 << g;
      tick();
      chk("d4_grant", b4.req_grant, g);
      chk("d4_valid", b4.cpu_valid, 1);
      chk("d4_addr", b4.cpu_addr, 32'h4000_0000 + g);
      b4.cpu_ready = 1'b1;
      tick();
      chk("d4_ready", b4.req_ready, oh);
      b4.cpu_ready = 1'b0;
      tick();
   endtask

   initial begin
      logic eg;
      rst2 = 1'b0;
      rst4 = 1'b0;
      b2.req_valid = '0; b2.req_addr = '0; b2.req_wdata = '0; b2.req_write = '0;
      b2.req_lock = '0; b2.cpu_ready = 1'b0; b2.cpu_rdata = '0;
      b4.req_valid = '0; b4.req_wdata = '0; b4.req_write = '0;
      b4.req_lock = '0; b4.cpu_ready = 1'b0; b4.cpu_rdata = '0;
      for (int i = 0; i < 4; i++) b4.req_addr[32*i +: 32] = 32'h4000_0000 + i;

      tick();
      tick();
      chk("rst_valid", b2.cpu_valid, 0);
      chk("rst_grant2", b2.req_grant, 1);
      chk("rst_ready", b2.req_ready, 0);
      chk("rst_addr", b2.cpu_addr, 0);
      chk("rst_grant4", b4.req_grant, 3);
      rst2 = 1'b1;
      rst4 = 1'b1;
      tick();

      // single write from requester 0, nubus master answers after 3 cycles
      b2.req_valid = 2'b01;
      b2.req_addr[31:0] = 32'hF000_0000;
      b2.req_wdata[31:0] = 32'h8765_4321;
      b2.req_write[3:0] = 4'b1111;
      tick();
      chk("wr_valid", b2.cpu_valid, 1);
      chk("wr_addr", b2.cpu_addr, 32'hF000_0000);
      chk("wr_wdata", b2.cpu_wdata, 32'h8765_4321);
      chk("wr_write", b2.cpu_write, 4'hF);
      chk("wr_grant", b2.req_grant, 0);
      chk("wr_lock", b2.cpu_lock, 0);
      tick();
      tick();
      chk("wr_valid_held", b2.cpu_valid, 1);
      chk("wr_no_ready", b2.req_ready, 0);
      b2.cpu_ready = 1'b1;
      tick();
      chk("wr_ready", b2.req_ready, 2'b01);
      chk("wr_valid_drop", b2.cpu_valid, 0);
      b2.cpu_ready = 1'b0;
      b2.req_valid = 2'b00;
      tick();
      chk("wr_ready_pulse", b2.req_ready, 0);

      // read back
      b2.req_valid = 2'b01;
      b2.req_write[3:0] = 4'b0000;
      tick();
      chk("rd_valid", b2.cpu_valid, 1);
      chk("rd_write", b2.cpu_write, 0);
      chk("rd_grant", b2.req_grant, 0);
      b2.cpu_ready = 1'b1;
      b2.cpu_rdata = 32'h8765_4321;
      tick();
      chk("rd_ready", b2.req_ready, 2'b01);
      chk("rd_rdata", b2.req_rdata, 32'h8765_4321);
      b2.cpu_ready = 1'b0;
      b2.req_valid = 2'b00;
      tick();

      // cpu_ready outside ISSUE must be ignored
      b2.cpu_ready = 1'b1;
      tick();
      tick();
      chk("idle_ready_ign", b2.req_ready, 0);
      chk("idle_valid", b2.cpu_valid, 0);
      b2.cpu_ready = 1'b0;

      // contention: last grant 0, so order is 1,0,1,0
      b2.req_valid = 2'b11;
      b2.req_addr[31:0] = 32'h0000_0100;
      b2.req_addr[63:32] = 32'h1000_1000;
      for (int t = 0; t < 4; t++) begin
         eg = (t % 2 == 0);
         tick();
         chk("ct_grant", b2.req_grant, eg);
         chk("ct_addr", b2.cpu_addr, eg ? 32'h1000_1000 : 32'h0000_0100);
         b2.cpu_ready = 1'b1;
         b2.cpu_rdata = 32'hA0 + t;
         tick();
         chk("ct_ready", b2.req_ready, eg ? 2'b10 : 2'b01);
         chk("ct_rdata", b2.req_rdata, 32'hA0 + t);
         b2.cpu_ready = 1'b0;
         tick();
      end
      b2.req_valid = 2'b00;
      tick();

      // locked sequence by requester 0 with requester 1 waiting
      b2.req_valid = 2'b01;
      b2.req_lock = 2'b01;
      b2.req_addr[31:0] = 32'hF000_0000;
      b2.req_addr[63:32] = 32'h2000_0000;
      b2.req_write[3:0] = 4'hF;
      tick();
      chk("lk1_grant", b2.req_grant, 0);
      chk("lk1_lock", b2.cpu_lock, 1);
      chk("lk1_addr", b2.cpu_addr, 32'hF000_0000);
      b2.req_valid = 2'b11;
      b2.cpu_ready = 1'b1;
      tick();
      chk("lk1_ready", b2.req_ready, 2'b01);
      b2.cpu_ready = 1'b0;
      b2.req_addr[31:0] = 32'hF000_0004;
      tick();
      chk("lk_hold_lock", b2.cpu_lock, 1);
      chk("lk_hold_valid", b2.cpu_valid, 0);
      tick();
      chk("lk2_addr", b2.cpu_addr, 32'hF000_0004);
      chk("lk2_grant", b2.req_grant, 0);
      chk("lk2_lock", b2.cpu_lock, 1);
      b2.cpu_ready = 1'b1;
      tick();
      chk("lk2_ready", b2.req_ready, 2'b01);
      b2.cpu_ready = 1'b0;
      b2.req_addr[31:0] = 32'hF000_0008;
      tick();
      tick();
      chk("lk3_addr", b2.cpu_addr, 32'hF000_0008);
      chk("lk3_grant", b2.req_grant, 0);
      chk("lk3_lock", b2.cpu_lock, 1);
      b2.cpu_ready = 1'b1;
      tick();
      chk("lk3_ready", b2.req_ready, 2'b01);
      b2.cpu_ready = 1'b0;
      b2.req_valid = 2'b10;
      b2.req_lock = 2'b00;
      tick();
      chk("unlk_hold", b2.cpu_lock, 1);
      tick();
      chk("unlk_lock", b2.cpu_lock, 0);
      chk("unlk_valid", b2.cpu_valid, 0);
      tick();
      chk("r1_grant", b2.req_grant, 1);
      chk("r1_addr", b2.cpu_addr, 32'h2000_0000);
      chk("r1_lock", b2.cpu_lock, 0);
      b2.cpu_ready = 1'b1;
      b2.cpu_rdata = 32'h5A5A_0001;
      tick();
      chk("r1_ready", b2.req_ready, 2'b10);
      b2.cpu_ready = 1'b0;
      b2.req_valid = 2'b00;
      tick();

      // reset in the middle of ISSUE
      b2.req_valid = 2'b01;
      b2.req_addr[31:0] = 32'h3000_0000;
      tick();
      chk("mr_valid", b2.cpu_valid, 1);
      chk("mr_grant", b2.req_grant, 0);
      #2;
      rst2 = 1'b0;
      #1;
      chk("mr_rst_valid", b2.cpu_valid, 0);
      chk("mr_rst_addr", b2.cpu_addr, 0);
      chk("mr_rst_wdata", b2.cpu_wdata, 0);
      chk("mr_rst_write", b2.cpu_write, 0);
      chk("mr_rst_lock", b2.cpu_lock, 0);
      chk("mr_rst_ready", b2.req_ready, 0);
      chk("mr_rst_rdata", b2.req_rdata, 0);
      chk("mr_rst_grant", b2.req_grant, 1);
      b2.req_valid = 2'b11;
      b2.cpu_ready = 1'b1;
      tick();
      chk("mr_hold_ready", b2.req_ready, 0);
      b2.cpu_ready = 1'b0;
      @(negedge clk);
      rst2 = 1'b1;
      tick();
      chk("mr_after_grant", b2.req_grant, 0);
      chk("mr_after_valid", b2.cpu_valid, 1);
      chk("mr_after_addr", b2.cpu_addr, 32'h3000_0000);

      // NUM_REQ=4 wrap: get grant 3, then 1001 -> 0, 3, 0
      b4.req_valid = 4'b1000;
      run4(2'd3);
      b4.req_valid = 4'b1001;
      run4(2'd0);
      run4(2'd3);
      run4(2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/nubus_master_arbiter.md
Name: nubus_master_arbiter

Overview:
- Shares the single CPU-side master port of the nubus block (cpu_valid/addr/wdata/write/lock/ready/rdata) between NUM_REQ local requesters (e.g. soft CPU, DMA engine).
- Round-robin grant; transaction fields are latched at grant and held stable until cpu_ready.
- Locked sequences (NuBus resource lock) keep the grant on one requester until it releases its lock.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- GW, $clog2(NUM_REQ), width of grant index; derived, not overridden.

Ports:
- nub_clkn  in  1  clock; all state updates on its rising edge (NuBus driving edge).
- nub_resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester transaction request; held until its req_ready pulse.
- req_addr  in  32*NUM_REQ  byte address; slice i = [32i+31:32i].
- req_wdata  in  32*NUM_REQ  write data.
- req_write  in  4*NUM_REQ  byte write strobes; 0 = read.
- req_lock  in  NUM_REQ  request to hold the bus lock across transactions.
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data, shared; valid while req_ready is high.
- req_grant  out  GW  index of current/last granted requester (debug/status).
- cpu_valid  out  1  to nubus master.
- cpu_addr  out  32  latched address.
- cpu_wdata  out  32  latched write data.
- cpu_write  out  4  latched strobes.
- cpu_lock  out  1  NuBus lock request.
- cpu_ready  in  1  completion from nubus master.
- cpu_rdata  in  32  read data from nubus master.

Behaviour:
- Reset (async, nub_resetn=0): state IDLE; cpu_valid=0, cpu_addr/wdata/write=0, cpu_lock=0, req_ready=0, req_rdata=0, req_grant=NUM_REQ-1 (so requester 0 wins first). A reset mid-transaction abandons it; no req_ready is issued.
- States: IDLE, ISSUE, DONE, HOLD.
- IDLE: if any req_valid, select winner by round-robin starting at req_grant+1 (mod NUM_REQ). Next edge: latch winner's addr/wdata/write into cpu_*, cpu_valid=1, cpu_lock=req_lock[winner], req_grant=winner, -> ISSUE. No request: stay; outputs hold, cpu_valid=0.
- ISSUE: cpu_valid=1, cpu_* stable. On edge where cpu_ready=1: cpu_valid<=0, req_rdata<=cpu_rdata, req_ready[req_grant]<=1, -> DONE. Changes on req_* inputs are ignored.
- DONE: req_ready pulse is exactly one cycle; requester must drop or replace req_valid on that edge. Next: req_ready<=0; if cpu_lock=1 -> HOLD, else -> IDLE.
- HOLD: only req_grant's requester is served. If req_lock[g]=0: cpu_lock<=0, -> IDLE (others may win next IDLE cycle). Else if req_valid[g]=1: latch its fields, cpu_valid<=1, cpu_lock stays 1, -> ISSUE. Other requesters wait indefinitely.
- Latency: req_valid in IDLE -> cpu_valid 1 cycle; cpu_ready -> req_ready 1 cycle; minimum back-to-back spacing per requester 3 cycles (IDLE->ISSUE->DONE).
- Simultaneous requests: exactly one grant; round-robin guarantees each valid requester is served within NUM_REQ unlocked transactions.
- Wrap-around: pointer search from req_grant+1 wraps NUM_REQ-1 -> 0.
- cpu_ready while not ISSUE: ignored.
- req_write=0 reads: req_rdata updated; for writes req_rdata also updated (value don't-care to requester).

Optional Feature:
- NUBUS_ARB_FIXED_PRIO_EN: defined -> IDLE selection is fixed priority, lowest index wins, req_grant still updated for status; HOLD unchanged. Undefined -> round-robin as above.

Test Plan:
- Single request: req_valid[0]=1, addr F0000000, write 1111, wdata 87654321, master cpu_ready after 3 cycles -> cpu_valid asserted 1 cycle after request with those values; req_ready[0] one-cycle pulse 1 cycle after cpu_ready; then read of F0000000 returns req_rdata=87654321.
- Contention: req_valid=2'b11 held continuously, NUM_REQ=2 -> grants alternate 0,1,0,1; req_grant follows; no req_ready to a non-granted requester.
- Lock: req0 lock=1 issues 3 writes (F0000000/4/8) while req1 valid -> cpu_lock=1 throughout, all 3 served before req1; req0 drops lock -> cpu_lock=0, req1 granted next.
- Reset mid-ISSUE: nub_resetn low while cpu_valid=1 -> all outputs 0 immediately (async), req_grant=NUM_REQ-1; after release, req 0 granted first.
- Wrap, NUM_REQ=4: last grant 3, requests 4'b1001 -> grant 0, then 3.
- NUBUS_ARB_FIXED_PRIO_EN defined, req_valid=2'b11 held -> requester 0 granted every time; requester 1 served only after req_valid[0] drops.
